muldiv_unit: RTL
================

# muldiv_unit

Parametrised multi-cycle RV32M/RV64M multiply/divide execute unit. It sits beside the integer ALU in the EX stage and takes one M-extension operation at a time over a valid/ready handshake. It returns the XLEN-bit result tagged with its destination register. While it is busy, the pipeline stall logic holds the EX stage.

## Interface
- XLEN, 32: operand/result width; legal values are 32 or 64.
- RD_W, 5: destination-register tag width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-low; all state clears at the edge where rst=0.
- flush  in  1  kill the in-flight op (branch/jump flush); takes priority over every other input.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- a, b  in  XLEN  rs1/rs2 values, already forwarded.
- rd_in  in  RD_W  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result.
- rd_out  out  RD_W  tag of the result.
- illegal  out  1  the op is unsupported in this build; valid only with out_valid.
- busy  out  1  high in any state except IDLE; drives the EX stall.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance is in_valid & in_ready at a rising edge. It latches op, rd_in, operand magnitudes, sign flags and a special-case flag.
- Next state from IDLE on acceptance:
  - MUL* → MUL.
  - DIV/REM with b==0 or signed overflow → DONE.
  - Other DIV/REM → DIV.
- MUL (one cycle):
  - Form the 2·XLEN product from the latched operands.
  - Signedness: MULH is s×s, MULHSU is s×u, MULHU is u×u.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - Next state → DONE.
- DIV: radix-2 restoring divide on magnitudes, one quotient bit per cycle, counter from XLEN-1 down to 0. When the counter reaches 0, the next state is DONE and the sign fix-up is applied at that edge:
  - Quotient is negated when sign(a)^sign(b) on signed ops.
  - Remainder takes sign(a).
- Division special cases (RISC-V spec):
  - b==0: quotient is all ones; remainder = a.
  - Signed a = -2^(XLEN-1) with b = -1: quotient = a; remainder = 0.
- DONE:
  - out_valid=1; result and rd_out stay stable until out_ready.
  - out_valid & out_ready → IDLE.
  - There is no same-cycle back-to-back acceptance: in_ready=0 in DONE.
- flush=1 in any state → IDLE at the next edge. out_valid drops and the result is discarded. A request presented in the same cycle as flush is not accepted.
- rst=0 mid-operation: the operation is abandoned identically to a flush, and all registers clear.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, rd_out=0, illegal=0, counter=0, state=IDLE.

## Timing
- Latency counts edges from the acceptance edge to out_valid=1:
  - Special-case divide: 1.
  - MUL*: 2.
  - DIV/REM: XLEN+1 (33 for XLEN=32).
- Outputs are registered; there is no combinational path from in_* to out_*.
- in_ready is a combinational function of state only. It does not depend on in_valid.
- With out_ready held high, the minimum spacing between acceptances is latency+1 cycles.

## Configuration
- MULDIV_DIV_EN defined: full behaviour as above.
- MULDIV_DIV_EN undefined:
  - The DIV state and the divider are not built.
  - DIV/DIVU/REM/REMU go IDLE→DONE with result=0 and illegal=1 (latency 1).
  - MUL* are unchanged.

## Structure
- Package muldiv_pkg:
  - op encoding localparams OP_MUL…OP_REMU (funct3 values 3'b000–3'b111).
  - state enum.
  - helper function for the signed-overflow test.
- Sub-module muldiv_div_core: the iterative restoring divider, started by a one-cycle start pulse. It holds quotient/remainder/counter registers and raises a one-cycle done. It is instantiated only under MULDIV_DIV_EN.

## Test plan
- MULH a=0x80000000, b=0x80000000 → result 0x40000000 at latency 2. MUL with the same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD, out_valid exactly 33 edges after acceptance. REM with the same operands → 0xFFFFFFFF.
- DIVU a=5, b=0 → 0xFFFFFFFF. REM a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with those operands → 0. Each at latency 1.
- Backpressure: result ready, out_ready held low for 10 cycles → result and rd_out stable, in_ready=0. Raising out_ready → IDLE on the next edge.
- flush at cycle 10 of a DIV → IDLE next edge, no out_valid. A subsequent MUL 3×4 → 12 with correct rd_out.
- rst=0 during DIV, then a build without MULDIV_DIV_EN → all outputs at reset values. DIVU 9/3 → result 0 with illegal=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and the signed-overflow test for the M-extension unit.
// Included by muldiv_unit and muldiv_div_core.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operands arrive zero-extended to 64 bits; xlen selects the live width.
  function automatic logic div_ovf(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned xlen);
    logic [63:0] min_neg;
    logic [63:0] all_ones;
    all_ones = (xlen >= 64) ? {64{1'b1}} : ((64'd1 << xlen) - 64'd1);
    min_neg  = 64'd1 << (xlen - 1);
    return (a == min_neg) && (b == all_ones);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on magnitudes: loads on start, one quotient bit per cycle, XLEN cycles.
// done is a one-cycle pulse on the final step; quo/rem carry that step's result, kill aborts.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] rem_step;

  // trial[XLEN] is the borrow: set means the divisor did not fit this step.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};
    rem_step = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    done     = active_q && (cnt_q == '0);
    quo      = quo_step;
    rem      = rem_step;
  end

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    if (kill) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = CW'(XLEN - 1);
      quo_d    = dividend;
      rem_d    = '0;
      dvs_d    = divisor;
    end else if (active_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multi-cycle mul/div unit; latency 2 (MUL*), XLEN+1 (DIV/REM), 1 (div special case).
// Result held in DONE until out_ready; flush wins over all inputs. MULDIV_DIV_EN builds the divider.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            illegal,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic [2*XLEN-1:0] prod_mag, prod;

  assign a_neg = a[XLEN-1] &&
                 ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
  assign b_neg = b[XLEN-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
  assign mag_a_in = a_neg ? -a : a;
  assign mag_b_in = b_neg ? -b : b;

  // Signed products are formed on magnitudes and negated once at the end.
  assign prod_mag = {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
  assign prod     = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;

`ifdef MULDIV_DIV_EN
  logic            b_zero, ovf, div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix;

  assign b_zero    = (b == '0);
  assign ovf       = ((op == OP_DIV) || (op == OP_REM)) && div_ovf(64'(a), 64'(b), XLEN);
  assign div_start = (state_q == ST_IDLE) && in_valid && !flush && op[2] && !b_zero && !ovf;
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? -div_quo : div_quo;
  assign rem_fix   = sign_a_q ? -div_rem : div_rem;

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .kill     (flush),
    .start    (div_start),
    .dividend (mag_a_in),
    .divisor  (mag_b_in),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d      = op;
            rd_d      = rd_in;
            mag_a_d   = mag_a_in;
            mag_b_d   = mag_b_in;
            sign_a_d  = a_neg;
            sign_b_d  = b_neg;
            illegal_d = 1'b0;
            if (!op[2]) begin
              state_d = ST_MUL;
            end else begin
`ifdef MULDIV_DIV_EN
              // b==0 and MIN/-1 have fixed answers, so skip the divider.
              if (b_zero) begin
                state_d  = ST_DONE;
                result_d = op[1] ? a : '1;
              end else if (ovf) begin
                state_d  = ST_DONE;
                result_d = op[1] ? '0 : a;
              end else begin
                state_d  = ST_DIV;
              end
`else
              state_d   = ST_DONE;
              result_d  = '0;
              illegal_d = 1'b1;
`endif
            end
          end
        end
        ST_MUL: begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = ST_DONE;
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (div_done) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign rd_out    = rd_q;
  assign illegal   = illegal_q;

endmodule
